ram_arbiter: RTL and testbench

Shares one synchronous single-port RAM between the instruction-fetch port and the load/store port of the mem stage. Each cycle it grants at most one requester, drives the RAM, and returns read data to the granted requester one cycle later. Per-port hold outputs stall the requesting pipeline stage. Load/store has fixed priority over fetch, with an optional starvation guard.

---
 rtl/ram_arbiter_pkg.sv | 18 +
 rtl/ram_arbiter_starve_ctr.sv | 46 ++++
 rtl/ram_arbiter.sv | 118 +++++++++++
 tb/tb_ram_arbiter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared definitions for the RAM arbiter.
//   - response-owner encodings (who receives the read data returning next cycle)
//   - memory data and address bus widths
//   - ZeroWord constant
package ram_arbiter_pkg;

  localparam int MemBus     = 32;
  localparam int MemAddrBus = 32;

  localparam logic [MemBus-1:0] ZeroWord = '0;

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_IF   = 2'd1,
    RSP_LS   = 2'd2
  } rsp_e;

endpackage

// File: rtl/ram_arbiter_starve_ctr.sv
// arb_starve_ctr: starvation guard for the fetch port.
// Counts consecutive load/store grants while fetch is waiting and raises
// force_if_o once STARVE_MAX such grants have been given.
// Ports:
//   clk, rstn     - clock, async active-low reset
//   if_req_i      - fetch request
//   if_gnt_i      - fetch granted this cycle
//   ls_gnt_i      - load/store granted this cycle
//   force_if_o    - grant fetch this cycle regardless of load/store
module arb_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic if_req_i,
  input  logic if_gnt_i,
  input  logic ls_gnt_i,
  output logic force_if_o
);

  localparam logic [3:0] CntMax = 4'(STARVE_MAX);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (if_gnt_i || !if_req_i) begin
      cnt_d = 4'd0;
    end else if (ls_gnt_i && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Depends only on registered count and the request, so no combinational
  // loop through the grant logic.
  assign force_if_o = if_req_i && (cnt_q == CntMax);

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one synchronous single-port RAM between the fetch port
// and the load/store port. Load/store has fixed priority; read data returns
// one cycle after grant to the port recorded in the response FSM.
// Ports:
//   clk, rstn                       - clock, async active-low reset
//   if_req_i/if_addr_i              - fetch request and byte address
//   if_gnt_o/if_rvalid_o/if_rdata_o - fetch grant and read response
//   hold_if_o                       - fetch requested but not granted
//   ls_req_i/ls_we_i/ls_wmask_i/ls_addr_i/ls_wdata_i - load/store request
//   ls_gnt_o/ls_rvalid_o/ls_rdata_o - load/store grant and load response
//   hold_ls_o                       - load/store requested but not granted
//   ram_*                           - RAM access port
// Build option: define ARB_STARVE_GUARD_EN to force a fetch grant after
// STARVE_MAX consecutive load/store grants with fetch pending.
//
// Response FSM:
//   state    | meaning
//   RSP_NONE | no read data due this cycle
//   RSP_IF   | RAM read data belongs to fetch
//   RSP_LS   | RAM read data belongs to a load
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  output logic        hold_if_o,
  input  logic        ls_req_i,
  input  logic        ls_we_i,
  input  logic [3:0]  ls_wmask_i,
  input  logic [31:0] ls_addr_i,
  input  logic [31:0] ls_wdata_i,
  output logic        ls_gnt_o,
  output logic        ls_rvalid_o,
  output logic [31:0] ls_rdata_o,
  output logic        hold_ls_o,
  output logic        ram_ce_o,
  output logic        ram_we_o,
  output logic [3:0]  ram_wmask_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  input  logic [31:0] ram_rdata_i
);

  rsp_e rsp_q, rsp_d;
  logic force_if;

`ifdef ARB_STARVE_GUARD_EN
  arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clk        (clk),
    .rstn       (rstn),
    .if_req_i   (if_req_i),
    .if_gnt_i   (if_gnt_o),
    .ls_gnt_i   (ls_gnt_o),
    .force_if_o (force_if)
  );
`else
  assign force_if = 1'b0;
`endif

  // Grants and RAM drive
  always_comb begin
    ls_gnt_o    = ls_req_i && !force_if;
    if_gnt_o    = if_req_i && (!ls_req_i || force_if);
    hold_if_o   = if_req_i && !if_gnt_o;
    hold_ls_o   = ls_req_i && !ls_gnt_o;

    ram_ce_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_wmask_o = 4'd0;
    ram_addr_o  = '0;
    ram_wdata_o = ZeroWord;
    if (if_gnt_o) begin
      ram_ce_o   = 1'b1;
      ram_addr_o = if_addr_i;
    end else if (ls_gnt_o) begin
      ram_ce_o    = 1'b1;
      ram_we_o    = ls_we_i;
      ram_wmask_o = ls_we_i ? ls_wmask_i : 4'd0;
      ram_addr_o  = ls_addr_i;
      ram_wdata_o = ls_wdata_i;
    end
  end

  // Response owner for next cycle; stores return nothing.
  always_comb begin
    rsp_d = RSP_NONE;
    if (if_gnt_o) begin
      rsp_d = RSP_IF;
    end else if (ls_gnt_o && !ls_we_i) begin
      rsp_d = RSP_LS;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_q <= RSP_NONE;
    end else begin
      rsp_q <= rsp_d;
    end
  end

  always_comb begin
    if_rvalid_o = (rsp_q == RSP_IF);
    ls_rvalid_o = (rsp_q == RSP_LS);
    if_rdata_o  = if_rvalid_o ? ram_rdata_i : ZeroWord;
    ls_rdata_o  = ls_rvalid_o ? ram_rdata_i : ZeroWord;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o, if_rvalid_o, hold_if_o;
  logic [31:0] if_rdata_o;
  logic        ls_req_i, ls_we_i;
  logic [3:0]  ls_wmask_i;
  logic [31:0] ls_addr_i, ls_wdata_i;
  logic        ls_gnt_o, ls_rvalid_o, hold_ls_o;
  logic [31:0] ls_rdata_o;
  logic        ram_ce_o, ram_we_o;
  logic [3:0]  ram_wmask_o;
  logic [31:0] ram_addr_o, ram_wdata_o;
  logic [31:0] ram_rdata_i;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .rstn(rstn),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .hold_if_o(hold_if_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_wmask_i(ls_wmask_i),
    .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o),
    .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o), .hold_ls_o(hold_ls_o),
    .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_wmask_o(ram_wmask_o),
    .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
  );

  // Behavioural single-port RAM, 64 words, one-cycle read latency.
  logic [31:0] mem [0:63];
  always @(posedge clk) begin
    if (ram_ce_o) begin
      if (ram_we_o) begin
        for (int b = 0; b < 4; b++)
          if (ram_wmask_o[b]) mem[ram_addr_o[7:2]][b*8 +: 8] <= ram_wdata_o[b*8 +: 8];
      end else begin
        ram_rdata_i <= mem[ram_addr_o[7:2]];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia,
                       input logic lr, input logic lw, input logic [3:0] lm,
                       input logic [31:0] la, input logic [31:0] ld);
    if_req_i = ir; if_addr_i = ia;
    ls_req_i = lr; ls_we_i = lw; ls_wmask_i = lm; ls_addr_i = la; ls_wdata_i = ld;
  endtask

  // Advance one cycle; leaves time 1 unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {if_gnt_o, if_rvalid_o, hold_if_o, ls_gnt_o, ls_rvalid_o, hold_ls_o,
              ram_ce_o, ram_we_o, ram_wmask_o}, 64'd0);
    chk({tag, "_data"}, {if_rdata_o, ls_rdata_o}, 64'd0);
    chk({tag, "_ram"}, {ram_addr_o, ram_wdata_o}, 64'd0);
  endtask

  logic exp_if [0:9];

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4]  = 32'hDEADBEEF;  // 0x10
    mem[8]  = 32'hAAAAAAAA;  // 0x20
    mem[9]  = 32'h0BADF00D;  // 0x24
    ram_rdata_i = 32'h5555_5555;
    rstn = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #12;
    chk_all_zero("reset");
    @(negedge clk); rstn = 1'b1;
    tick();

    // Fetch only
    drive(1, 32'h10, 0, 0, 0, 0, 0);
    #1;
    chk("if_only_gnt", {if_gnt_o, hold_if_o, ls_gnt_o, hold_ls_o}, 4'b1000);
    chk("if_only_ram", {ram_ce_o, ram_we_o, ram_wmask_o, ram_addr_o}, {1'b1, 1'b0, 4'h0, 32'h10});
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("if_only_rsp", {if_rvalid_o, ls_rvalid_o, if_rdata_o}, {2'b10, 32'hDEADBEEF});
    tick();

    // Store then load same address
    drive(0, 0, 1, 1, 4'b0011, 32'h20, 32'h12345678);
    #1;
    chk("st_gnt", {ls_gnt_o, if_gnt_o, hold_ls_o}, 3'b100);
    chk("st_ram", {ram_ce_o, ram_we_o, ram_wmask_o, ram_wdata_o}, {1'b1, 1'b1, 4'b0011, 32'h12345678});
    tick();
    drive(0, 0, 1, 0, 4'b1111, 32'h20, 32'hFFFFFFFF);
    #1;
    chk("st_no_rvalid", {ls_rvalid_o, if_rvalid_o}, 2'b00);
    chk("ld_ram", {ram_ce_o, ram_we_o, ram_wmask_o, ram_addr_o}, {1'b1, 1'b0, 4'h0, 32'h20});
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("ld_rsp", {ls_rvalid_o, if_rvalid_o, ls_rdata_o, if_rdata_o}, {2'b10, 32'hAAAA5678, 32'h0});
    tick();

    // Both requesting continuously; counter starts cleared (if_req was 0).
`ifdef ARB_STARVE_GUARD_EN
    for (int k = 0; k < 10; k++) exp_if[k] = ((k % 5) == 4);
`else
    for (int k = 0; k < 10; k++) exp_if[k] = 1'b0;
`endif
    drive(1, 32'h10, 1, 0, 0, 32'h20, 0);
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("both_gnt%0d", k), {if_gnt_o, ls_gnt_o, hold_if_o, hold_ls_o},
          {exp_if[k], !exp_if[k], !exp_if[k], exp_if[k]});
      if (k > 0)
        chk($sformatf("both_rsp%0d", k), {if_rvalid_o, ls_rvalid_o}, {exp_if[k-1], !exp_if[k-1]});
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("both_last_rsp", {if_rvalid_o, ls_rvalid_o}, {exp_if[9], !exp_if[9]});
    tick();

    // Reset asserted before the load response can be registered
    drive(0, 0, 1, 0, 0, 32'h20, 0);
    #1;
    chk("rst_ld_gnt", ls_gnt_o, 1'b1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    rstn = 1'b0;
    tick();
    chk("rst_no_rvalid", ls_rvalid_o, 1'b0);
    chk_all_zero("in_reset");
    @(negedge clk); rstn = 1'b1;
    tick();
    chk("rst_after_rvalid", {ls_rvalid_o, if_rvalid_o}, 2'b00);
    chk_all_zero("after_reset");

    // Alternating owners
    drive(1, 32'h10, 0, 0, 0, 0, 0);
    #1;
    chk("alt_if_gnt", {if_gnt_o, ls_gnt_o}, 2'b10);
    tick();
    drive(0, 0, 1, 0, 0, 32'h20, 0);
    #1;
    chk("alt_ls_gnt", {if_gnt_o, ls_gnt_o}, 2'b01);
    chk("alt_rsp1", {if_rvalid_o, ls_rvalid_o, if_rdata_o, ls_rdata_o}, {2'b10, 32'hDEADBEEF, 32'h0});
    tick();
    drive(1, 32'h24, 0, 0, 0, 0, 0);
    #1;
    chk("alt_if2_gnt", {if_gnt_o, ls_gnt_o, ram_addr_o}, {2'b10, 32'h24});
    chk("alt_rsp2", {if_rvalid_o, ls_rvalid_o, if_rdata_o, ls_rdata_o}, {2'b01, 32'h0, 32'hAAAA5678});
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("alt_rsp3", {if_rvalid_o, ls_rvalid_o, if_rdata_o, ls_rdata_o}, {2'b10, 32'h0BADF00D, 32'h0});
    tick();
    chk_all_zero("idle_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
